// File: rtl/csla_pkg.sv
// Shared types and constants for the 64-bit carry-select accumulator.
// Holds the FSM state enum, the datapath width and the saturation value.
package csla_pkg;

    localparam int DATA_W = 64;

    localparam logic [DATA_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csla_64bit.sv
// Combinational 64-bit carry-select adder built from BLK-bit blocks.
// Ports: a, b operands; cin carry in; sum result; cout carry out.
module csla_64bit
    import csla_pkg::*;
#(
    parameter int BLK = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int NB = DATA_W / BLK;

    logic [NB:0] w_c;

    assign w_c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] w_s0;
        logic [BLK:0] w_s1;

        // Each block precomputes both carry-in cases; the incoming
        // carry only drives the select, not a ripple through the block.
        assign w_s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign w_s1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]}
                    + (BLK+1)'(1);

        assign sum[g*BLK +: BLK] = w_c[g] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
        assign w_c[g+1]          = w_c[g] ? w_s1[BLK]     : w_s0[BLK];
    end

    assign cout = w_c[NB];

endmodule

// File: rtl/csla_accum_64.sv
// Burst accumulator: sums 64-bit beats with a carry-select adder and
// presents sum, sticky overflow and saturating beat count per burst.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_last beat
// input; out_valid/out_ready/out_sum/out_ovf/out_cnt burst result.
// Define CSLA_ACCUM_SAT_EN to saturate the sum instead of wrapping.
module csla_accum_64
    import csla_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_osum;
    logic                r_oovf;
    logic [CNT_W-1:0]    r_ocnt;

    logic                w_idle;
    logic                w_take;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_sum;
    logic                w_cout;
    logic [DATA_W-1:0]   w_acc_nx;
    logic                w_ovf_nx;
    logic [CNT_W-1:0]    w_cnt_nx;

    assign w_idle = (r_state == S_IDLE);
    assign w_take = in_valid & in_ready;

    // A fresh burst starts from zero, so IDLE feeds 0 to the adder.
    assign w_a = w_idle ? '0 : r_acc;

    csla_64bit u_add (
        .a    (w_a),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

`ifdef CSLA_ACCUM_SAT_EN
    // Once pinned at ACC_MAX any further nonzero beat carries out again,
    // so the accumulator stays saturated for the rest of the burst.
    assign w_acc_nx = w_cout ? ACC_MAX : w_sum;
`else
    assign w_acc_nx = w_sum;
`endif

    assign w_ovf_nx = w_idle ? 1'b0 : (r_ovf | w_cout);
    assign w_cnt_nx = w_idle ? CNT_W'(1)
                    : (&r_cnt) ? r_cnt
                    : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_osum  <= '0;
            r_oovf  <= 1'b0;
            r_ocnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_take) begin
                        r_acc <= w_acc_nx;
                        r_ovf <= w_ovf_nx;
                        r_cnt <= w_cnt_nx;
                        if (in_last) begin
                            r_state <= S_DONE;
                            r_osum  <= w_acc_nx;
                            r_oovf  <= w_ovf_nx;
                            r_ocnt  <= w_cnt_nx;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_osum;
    assign out_ovf   = r_oovf;
    assign out_cnt   = r_ocnt;

endmodule

// File: tb/tb_csla_accum_64.sv
// Self-checking bench for csla_accum_64 (default and narrow counter).
// Beats are recorded in a queue and the burst result is modelled from totals.
module tb_csla_accum_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_ovf;
    logic [15:0] out_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [63:0] out_sum2;
    logic        out_ovf2;
    logic [1:0]  out_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] q[$];

    always #5 clk = ~clk;

    csla_accum_64 #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_cnt(out_cnt)
    );

    csla_accum_64 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_ovf(out_ovf2), .out_cnt(out_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = {$urandom, $urandom};
        q.push_back(d);
    endtask

    // Expected result from the exact (unbounded) total of the burst.
    task automatic expect_result(input string tag);
        logic [127:0] t;
        logic         e_ovf;
        logic [63:0]  e_sum;
        int           n;
        int           k;
        t = '0;
        foreach (q[i]) t += {64'd0, q[i]};
        n     = q.size();
        e_ovf = (t[127:64] != 0);
`ifdef CSLA_ACCUM_SAT_EN
        e_sum = e_ovf ? 64'hFFFF_FFFF_FFFF_FFFF : t[63:0];
`else
        e_sum = t[63:0];
`endif
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, ".latency"}, 64'(k), 64'd0);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".sum"}, out_sum, e_sum);
        chk({tag, ".ovf"}, 64'(out_ovf), 64'(e_ovf));
        chk({tag, ".cnt"}, 64'(out_cnt), 64'((n > 65535) ? 65535 : n));
        chk({tag, ".valid2"}, 64'(out_valid2), 64'd1);
        chk({tag, ".sum2"}, out_sum2, e_sum);
        chk({tag, ".cnt2"}, 64'(out_cnt2), 64'((n > 3) ? 3 : n));
        q.delete();
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".rel_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".rel_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] hs;
        logic [15:0] hc;
        logic        ho;
        int          acc_n;
        int          cyc;
        int          len;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.sum", out_sum, 64'd0);
        chk("rst.ovf", 64'(out_ovf), 64'd0);
        chk("rst.cnt", 64'(out_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        beat(64'd5, 1'b0);
        beat(64'd7, 1'b0);
        beat(64'd9, 1'b1);
        expect_result("b579");
        release_out("b579");

        beat(64'h1234, 1'b1);
        expect_result("single");
        release_out("single");

        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        beat(64'd2, 1'b1);
        expect_result("ovf");
        release_out("ovf");

        beat(64'd100, 1'b0);
        beat(64'd23, 1'b1);
        expect_result("hold");
        hs = out_sum;
        hc = out_cnt;
        ho = out_ovf;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("hold.in_ready", 64'(in_ready), 64'd0);
            chk("hold.valid", 64'(out_valid), 64'd1);
            chk("hold.sum", out_sum, hs);
            chk("hold.cnt", 64'(out_cnt), 64'(hc));
            chk("hold.ovf", 64'(out_ovf), 64'(ho));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_out("hold");

        beat(64'd10, 1'b0);
        beat(64'd20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 64'(out_valid), 64'd0);
        chk("mrst.in_ready", 64'(in_ready), 64'd1);
        chk("mrst.sum", out_sum, 64'd0);
        chk("mrst.cnt", 64'(out_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("mrst.novalid", 64'(out_valid), 64'd0);
        end
        beat(64'd3, 1'b0);
        beat(64'd4, 1'b1);
        expect_result("after_rst");
        release_out("after_rst");

        acc_n = 0;
        cyc   = 0;
        while (acc_n < 10 && cyc < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = in_valid ? 64'd1 : {$urandom, $urandom};
            in_last  = in_valid ? (acc_n == 9) : 1'($urandom_range(0, 1));
            @(posedge clk);
            if (in_valid && in_ready) begin
                acc_n++;
                q.push_back(64'd1);
            end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("toggle.budget", 64'(acc_n), 64'd10);
        expect_result("toggle");
        release_out("toggle");

        for (int b = 0; b < 20; b++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_data = {$urandom, $urandom};
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 2) == 0)
                    beat({32'hFFFF_FFFF, $urandom}, i == len - 1);
                else
                    beat({$urandom, $urandom}, i == len - 1);
            end
            expect_result("rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_out("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/csla_accum_64.md
CSLA_ACCUM_64 -- requirements
Module: csla_accum_64

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the beat counter.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand beat valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-006 SHALL have port in_data, input, 64, unsigned operand beat.
REQ-007 SHALL have port in_last, input, 1, the beat is the final beat of the burst.
REQ-008 SHALL have port out_valid, output, 1, burst result available.
REQ-009 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-010 SHALL have port out_sum, output, 64, accumulated burst sum.
REQ-011 SHALL have port out_ovf, output, 1, sticky unsigned overflow for the burst.
REQ-012 SHALL have port out_cnt, output, CNT_W, number of beats in the burst, saturating.

Function
REQ-013 SHALL implement an FSM with states IDLE, ACC and DONE.
REQ-014 SHALL define a beat as accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-015 SHALL drive in_ready to 1 in IDLE and ACC, and to 0 in DONE.
REQ-016 SHALL, on a beat accepted in IDLE, load acc = 0 + in_data, set ovf = 0 and cnt = 1.
REQ-017 SHALL, on a beat accepted in ACC, set acc = acc + in_data through the carry-select adder with cin = 0, and set ovf to ovf OR cout.
REQ-018 SHALL increment cnt on each accepted beat and hold it at 2^CNT_W-1 once it reaches that value.
REQ-019 SHALL transition IDLE->ACC on an accepted beat with in_last = 0.
REQ-020 SHALL transition IDLE->DONE or ACC->DONE on an accepted beat with in_last = 1.
REQ-021 SHALL transition DONE->IDLE on the edge where out_ready = 1.
REQ-022 SHALL hold the state when no beat is accepted.
REQ-023 SHALL assert out_valid exactly while in DONE, one cycle after the last beat is accepted; this is the latency.
REQ-024 SHALL keep out_sum, out_ovf and out_cnt stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL keep out_sum, out_ovf and out_cnt at their last values outside DONE; they are don't-care for the consumer.
REQ-026 SHALL treat in_last on a single-beat burst in IDLE as a complete burst with out_sum = in_data and out_cnt = 1.
REQ-027 SHALL ignore in_data and in_last when in_valid = 0.
REQ-028 SHALL make the sum wrap modulo 2^64 when saturation is disabled.

Reset
REQ-029 SHALL, while rst_n = 0, force the state to IDLE, acc = 0, ovf = 0 and cnt = 0.
REQ-030 SHALL hold out_valid = 0, in_ready = 1, out_sum = 0, out_ovf = 0 and out_cnt = 0 while rst_n = 0.
REQ-031 SHALL, when reset asserts mid-burst or in DONE, abort the burst and discard the result with no output.

Configuration
REQ-032 SHALL support the macro CSLA_ACCUM_SAT_EN.
REQ-033 SHALL, when CSLA_ACCUM_SAT_EN is defined, set acc = 64'hFFFF_FFFF_FFFF_FFFF on any beat whose cout = 1, and keep acc saturated for the rest of the burst.
REQ-034 SHALL, when CSLA_ACCUM_SAT_EN is undefined, wrap acc per REQ-028; out_ovf behaviour is identical in both builds.

Structure
REQ-035 SHALL place the FSM state enum, DATA_W = 64 and the saturation constant ACC_MAX in shared package csla_pkg.
REQ-036 SHALL instantiate exactly one csla_64bit as the combinational sub-module, with a = acc (or 0 in IDLE), b = in_data and cin = 0.
REQ-037 SHALL keep all registers in csla_accum_64 and add no extra pipeline stage inside the adder path.

Verification
REQ-038 SHALL cover: beats 5, 7, 9 (last on 9), out_ready = 1 -> out_valid one cycle later, out_sum = 21, out_cnt = 3, out_ovf = 0.
REQ-039 SHALL cover: a single beat 0x1234 with in_last -> out_sum = 0x1234, out_cnt = 1.
REQ-040 SHALL cover: beats 0xFFFF_FFFF_FFFF_FFFF then 2 (last) -> out_ovf = 1; out_sum = 1 without the macro and 0xFFFF_FFFF_FFFF_FFFF with CSLA_ACCUM_SAT_EN.
REQ-041 SHALL cover: out_ready held 0 for 4 cycles in DONE -> in_ready = 0 and outputs stable throughout; IDLE entered on the edge out_ready rises.
REQ-042 SHALL cover: rst_n pulsed low after 2 of 4 beats -> out_valid never asserts; a new burst 3, 4 (last) -> out_sum = 7, out_cnt = 2.
REQ-043 SHALL cover: in_valid toggled randomly within a burst of 10 beats of value 1 -> out_sum = 10, out_cnt = 10.
